// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PIDs, ULPI TXCMD prefix, CRC16 constants
// and the transmit engine state encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [1:0] TXCMD_PREFIX = 2'b01;

    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_WAIT_BUS,
        STATE_CMD,
        STATE_DATA,
        STATE_CRC_LO,
        STATE_CRC_HI,
        STATE_STOP,
        STATE_ABORT
    } state_t;

    function automatic logic [7:0] txcmd(input logic [3:0] pid);
        return {TXCMD_PREFIX, 2'b00, pid};
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/ulpi_tx_engine_if.sv
// Protocol-FSM side of the ULPI transmit engine: packet request,
// payload byte stream and completion status.
interface ulpi_tx_engine_if;

    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_zlp;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_last;
    logic       pl_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_aborted;

    modport master (
        output tx_start, tx_pid, tx_zlp,
        output pl_valid, pl_data, pl_last,
        input  pl_ready, tx_busy, tx_done, tx_aborted
    );

    modport slave (
        input  tx_start, tx_pid, tx_zlp,
        input  pl_valid, pl_data, pl_last,
        output pl_ready, tx_busy, tx_done, tx_aborted
    );

endinterface

// File: rtl/usb_crc16.sv
// Combinational USB CRC16 step over one byte, LSB first (reflected form).
// The CRC register itself lives in the instantiating block.
module usb_crc16
    import usb_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i])
                crc_next = (crc_next >> 1) ^ CRC16_POLY;
            else
                crc_next = crc_next >> 1;
        end
    end

endmodule

// File: rtl/ulpi_tx_engine.sv
// Link-side ULPI transmit engine: TXCMD, NXT-paced payload, CRC16 and STP
// generation for one USB packet per tx_start.
module ulpi_tx_engine
    import usb_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       CLKOUT,
    input  logic       RESET,
    input  logic       DIR,
    input  logic       NXT,
    output logic       STP,
    output logic [7:0] data_out,
    ulpi_tx_engine_if.slave tx
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

    state_t        state, state_n;
    logic [3:0]    pid_r;
    logic          zlp_r;
    logic [7:0]    cur;
    logic          cur_last;
    logic [15:0]   crc, crc_n, crc_upd;
    logic [CW-1:0] cnt, cnt_inc;
    logic [7:0]    dout_n;
    logic          ready, crc_en, phy_abort, underrun, accept;

    usb_crc16 u_crc (
        .crc      (crc),
        .data     (cur),
        .crc_next (crc_upd)
    );

    assign accept      = (state == STATE_IDLE) && tx.tx_start;
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign tx.pl_ready = ready;

    always_ff @(posedge CLKOUT or negedge RESET) begin
        if (!RESET) state <= STATE_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ready     = 1'b0;
        crc_en    = 1'b0;
        phy_abort = 1'b0;
        unique case (state)
            STATE_IDLE:
                if (tx.tx_start) state_n = STATE_WAIT_BUS;
            STATE_WAIT_BUS:
                if (!DIR && !NXT) state_n = STATE_CMD;
            STATE_CMD:
                if (DIR && NXT) begin
                    phy_abort = 1'b1;
                    state_n   = STATE_IDLE;
                end else if (DIR) begin
                    state_n = STATE_WAIT_BUS;
                end else if (NXT) begin
                    if (!is_data_pid(pid_r)) begin
                        state_n = STATE_STOP;
                    end else if (zlp_r) begin
                        state_n = STATE_CRC_LO;
                    end else begin
                        ready   = 1'b1;
                        state_n = STATE_DATA;
                    end
                end
            STATE_DATA:
                if (DIR) begin
                    phy_abort = 1'b1;
                    state_n   = STATE_IDLE;
                end else if (NXT) begin
                    crc_en = 1'b1;
                    if (cur_last) state_n = STATE_CRC_LO;
                    else          ready   = 1'b1;
                end
            STATE_CRC_LO, STATE_CRC_HI:
                if (DIR) begin
                    phy_abort = 1'b1;
                    state_n   = STATE_IDLE;
                end else if (NXT) begin
                    state_n = (state == STATE_CRC_LO) ? STATE_CRC_HI
                                                      : STATE_STOP;
                end
            STATE_STOP, STATE_ABORT:
                state_n = STATE_IDLE;
            default:
                state_n = STATE_IDLE;
        endcase

        // A requested byte that is missing, or a payload that would exceed
        // MAX_LEN, becomes a ULPI packet abort instead of a truncated packet.
        underrun = ready && (!tx.pl_valid ||
                             (cnt_inc == CNT_MAX && !tx.pl_last));
        if (underrun) state_n = STATE_ABORT;

        if (accept)      crc_n = CRC16_INIT;
        else if (crc_en) crc_n = crc_upd;
        else             crc_n = crc;

        dout_n = 8'h00;
        unique case (state_n)
            STATE_CMD:    dout_n = txcmd(pid_r);
            STATE_DATA:   dout_n = ready ? tx.pl_data : cur;
            STATE_CRC_LO: dout_n = ~crc_n[7:0];
            STATE_CRC_HI: dout_n = ~crc_n[15:8];
            STATE_ABORT:  dout_n = 8'hFF;
            default:      dout_n = 8'h00;
        endcase
    end

    always_ff @(posedge CLKOUT or negedge RESET) begin
        if (!RESET) begin
            pid_r         <= '0;
            zlp_r         <= 1'b0;
            cur           <= '0;
            cur_last      <= 1'b0;
            crc           <= CRC16_INIT;
            cnt           <= '0;
            STP           <= 1'b0;
            data_out      <= 8'h00;
            tx.tx_busy    <= 1'b0;
            tx.tx_done    <= 1'b0;
            tx.tx_aborted <= 1'b0;
        end else begin
            crc           <= crc_n;
            data_out      <= dout_n;
            STP           <= (state_n == STATE_STOP) ||
                             (state_n == STATE_ABORT);
            tx.tx_busy    <= state_n != STATE_IDLE;
            tx.tx_done    <= state_n == STATE_STOP;
            tx.tx_aborted <= phy_abort || (state_n == STATE_ABORT);
            if (accept) begin
                pid_r <= tx.tx_pid;
                zlp_r <= tx.tx_zlp;
                cnt   <= '0;
            end
            if (ready) begin
                cur      <= tx.pl_data;
                cur_last <= tx.pl_last;
                cnt      <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_ulpi_tx_engine.sv
// Self-checking bench for ulpi_tx_engine: vector table, directed ULPI
// corner sequences and randomized packets against a wire-level model.
module tb_ulpi_tx_engine;
    import usb_pkg::*;

    localparam int MAX_LEN = 16;

    logic       CLKOUT = 1'b0;
    logic       RESET;
    logic       DIR;
    logic       NXT;
    logic       STP;
    logic [7:0] data_out;

    ulpi_tx_engine_if tx ();

    ulpi_tx_engine #(.MAX_LEN(MAX_LEN)) dut (
        .CLKOUT   (CLKOUT),
        .RESET    (RESET),
        .DIR      (DIR),
        .NXT      (NXT),
        .STP      (STP),
        .data_out (data_out),
        .tx       (tx)
    );

    always #5 CLKOUT = ~CLKOUT;

    typedef struct {
        logic [3:0] pid;
        logic       zlp;
        int         len;
        int         nvalid;
        bit         give_last;
        int         pct;
        logic [7:0] cmd;
        int         nbytes;
        int         endk;
        bit         setup;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:79];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_end;
    int         pl_idx;
    int         cur_len;
    int         cur_nvalid;
    bit         cur_give_last;
    logic [7:0] setup_b [0:7];
    vec_t       vecs [15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKOUT);
        #1;
    endtask

    task automatic drive_pl();
        tx.pl_valid = pl_idx < cur_nvalid;
        tx.pl_data  = tx.pl_valid ? pay[pl_idx] : 8'($urandom);
        tx.pl_last  = tx.pl_valid && cur_give_last && (pl_idx == cur_len - 1);
    endtask

    // CRC16 computed in the non-reflected domain (poly 0x8005, bits fed
    // LSB first per byte), then mapped to the wire value: ~bit-reverse.
    function automatic logic [15:0] usb_crc(input int n);
        logic [15:0] r;
        logic [15:0] rv;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ pay[i][b];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        rv = {<<{r}};
        return ~rv;
    endfunction

    // Expected accepted bytes and end kind (0 done, 1 underrun, 2 PHY abort).
    task automatic model(input logic [3:0] pid, input logic zlp);
        int          k;
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back({4'h4, pid});
        exp_end = 0;
        if (pid[1:0] != 2'b11) return;
        k = 0;
        if (!zlp) begin
            for (int i = 0; i < 80; i++) begin
                if (i >= cur_nvalid ||
                    (i + 1 == MAX_LEN &&
                     !(cur_give_last && i == cur_len - 1))) begin
                    exp_end = 1;
                    return;
                end
                exp_q.push_back(pay[i]);
                k = i + 1;
                if (cur_give_last && i == cur_len - 1) break;
            end
        end
        c = usb_crc(k);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic run_pkt(input logic [3:0] pid, input logic zlp,
                           input int nxt_pct, input string tag,
                           output int endk);
        int         last_acc, gap, hold_err;
        bit         sending, held;
        logic [7:0] hv, e_dout;
        logic       nx, rdy, e_done, e_busy;
        got_q.delete();
        pl_idx = 0;
        drive_pl();
        tx.tx_pid   = pid;
        tx.tx_zlp   = zlp;
        tx.tx_start = 1'b1;
        tick();
        check({tag, "_busy"}, tx.tx_busy, 1);
        sending  = 0;
        held     = 0;
        hold_err = 0;
        last_acc = -10;
        gap      = 0;
        endk     = 3;
        e_dout   = 8'h00;
        e_done   = 1'b0;
        e_busy   = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (held && data_out !== hv) hold_err++;
            if (STP || tx.tx_aborted) begin
                endk   = tx.tx_aborted ? (STP ? 1 : 2) : 0;
                e_dout = data_out;
                e_done = tx.tx_done;
                e_busy = tx.tx_busy;
                gap    = cyc - last_acc;
                break;
            end
            if (data_out == txcmd(pid)) sending = 1;
            nx          = sending && ($urandom_range(0, 99) < nxt_pct);
            NXT         = nx;
            tx.tx_start = $urandom_range(0, 3) == 0;
            tx.tx_pid   = 4'($urandom);
            tx.tx_zlp   = 1'($urandom);
            @(negedge CLKOUT);
            rdy = tx.pl_ready;
            if (nx) begin
                got_q.push_back(data_out);
                last_acc = cyc;
            end
            held = sending && !nx;
            hv   = data_out;
            tick();
            if (rdy) begin
                pl_idx++;
                drive_pl();
            end
        end
        NXT         = 1'b0;
        tx.tx_start = 1'b0;
        check({tag, "_end_kind"}, endk, exp_end);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_stp_gap"}, gap, 1);
        check({tag, "_end_dout"}, e_dout, exp_end == 1 ? 8'hFF : 8'h00);
        check({tag, "_end_done"}, e_done, exp_end == 0);
        check({tag, "_end_busy"}, e_busy, 1);
        check({tag, "_hold"}, hold_err, 0);
        tick();
        check({tag, "_idle_after"},
              {tx.tx_busy, STP, tx.tx_done, tx.tx_aborted, data_out}, 0);
    endtask

    task automatic start_pkt(input logic [3:0] pid, input logic zlp);
        tx.tx_pid   = pid;
        tx.tx_zlp   = zlp;
        tx.tx_start = 1'b1;
        tick();
        tx.tx_start = 1'b0;
    endtask

    task automatic set_payload(input int len, input int nvalid,
                               input bit give_last, input bit setup);
        cur_len       = len;
        cur_nvalid    = nvalid;
        cur_give_last = give_last;
        for (int i = 0; i < 80; i++)
            pay[i] = (setup && i < 8) ? setup_b[i] : 8'($urandom);
        pl_idx = 0;
        drive_pl();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   endk;
        int   len;
        logic [3:0] pid;
        logic zlp;

        setup_b = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        vecs[0]  = '{PID_ACK,   1'b0, 0,  0,  1'b0, 100, 8'h42, 1,  0, 1'b0};
        vecs[1]  = '{PID_ACK,   1'b1, 0,  0,  1'b0, 100, 8'h42, 1,  0, 1'b0};
        vecs[2]  = '{PID_DATA1, 1'b1, 0,  0,  1'b0, 100, 8'h4B, 3,  0, 1'b0};
        vecs[3]  = '{PID_DATA0, 1'b0, 8,  8,  1'b1, 100, 8'h43, 11, 0, 1'b1};
        vecs[4]  = '{PID_DATA0, 1'b0, 8,  8,  1'b1, 40,  8'h43, 11, 0, 1'b1};
        vecs[5]  = '{PID_NAK,   1'b0, 0,  0,  1'b0, 50,  8'h4A, 1,  0, 1'b0};
        vecs[6]  = '{PID_STALL, 1'b0, 0,  0,  1'b0, 100, 8'h4E, 1,  0, 1'b0};
        vecs[7]  = '{PID_MDATA, 1'b0, 16, 16, 1'b1, 70,  8'h4F, 19, 0, 1'b0};
        vecs[8]  = '{PID_DATA2, 1'b0, 1,  1,  1'b1, 100, 8'h47, 4,  0, 1'b0};
        vecs[9]  = '{PID_DATA1, 1'b0, 20, 20, 1'b0, 80,  8'h4B, 16, 1, 1'b0};
        vecs[10] = '{PID_DATA0, 1'b0, 6,  3,  1'b1, 60,  8'h43, 4,  1, 1'b0};
        vecs[11] = '{PID_DATA0, 1'b0, 4,  0,  1'b1, 100, 8'h43, 1,  1, 1'b0};
        vecs[12] = '{PID_IN,    1'b0, 0,  0,  1'b0, 100, 8'h49, 1,  0, 1'b0};
        vecs[13] = '{PID_SETUP, 1'b0, 0,  0,  1'b0, 30,  8'h4D, 1,  0, 1'b0};
        vecs[14] = '{PID_OUT,   1'b0, 0,  0,  1'b0, 100, 8'h41, 1,  0, 1'b0};

        RESET       = 1'b0;
        DIR         = 1'b0;
        NXT         = 1'b1;
        tx.tx_start = 1'b1;
        tx.tx_pid   = PID_ACK;
        tx.tx_zlp   = 1'b0;
        set_payload(0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        check("reset_outputs",
              {STP, data_out, tx.tx_busy, tx.tx_done, tx.tx_aborted}, 0);
        check("reset_pl_ready", tx.pl_ready, 0);
        NXT         = 1'b0;
        tx.tx_start = 1'b0;
        @(negedge CLKOUT);
        RESET = 1'b1;
        tick();

        foreach (vecs[v]) begin
            set_payload(vecs[v].len, vecs[v].nvalid, vecs[v].give_last,
                        vecs[v].setup);
            model(vecs[v].pid, vecs[v].zlp);
            run_pkt(vecs[v].pid, vecs[v].zlp, vecs[v].pct,
                    $sformatf("vec%0d", v), endk);
            check($sformatf("vec%0d_cmd", v),
                  got_q.size() > 0 ? got_q[0] : 8'hxx, vecs[v].cmd);
            check($sformatf("vec%0d_count", v), got_q.size(), vecs[v].nbytes);
            check($sformatf("vec%0d_kind", v), endk, vecs[v].endk);
        end

        // ACK answered on the first TXCMD cycle: exact cycle positions.
        start_pkt(PID_ACK, 1'b0);
        check("ack_c1_dout", data_out, 8'h00);
        check("ack_c1_busy", tx.tx_busy, 1);
        tick();
        check("ack_c2_txcmd", {STP, data_out}, {1'b0, 8'h42});
        NXT = 1'b1;
        tick();
        NXT = 1'b0;
        check("ack_c3_stop", {STP, data_out, tx.tx_done}, {1'b1, 8'h00, 1'b1});
        tick();
        check("ack_c4_idle", {tx.tx_busy, STP, tx.tx_done}, 0);

        // DIR in CMD before NXT: back to WAIT_BUS, TXCMD resent.
        start_pkt(PID_ACK, 1'b0);
        tick();
        DIR = 1'b1;
        tick();
        check("retry_wait",
              {tx.tx_aborted, STP, data_out, tx.tx_busy}, {11'h0, 1'b1});
        tick();
        check("retry_hold", {tx.tx_aborted, data_out}, 0);
        DIR = 1'b0;
        tick();
        check("retry_txcmd", data_out, 8'h42);
        NXT = 1'b1;
        tick();
        NXT = 1'b0;
        check("retry_stop", {STP, tx.tx_done, tx.tx_aborted}, 3'b110);
        tick();

        // DIR together with NXT in CMD is a PHY abort.
        start_pkt(PID_ACK, 1'b0);
        tick();
        DIR = 1'b1;
        NXT = 1'b1;
        tick();
        check("cmd_abort",
              {tx.tx_aborted, STP, tx.tx_busy, data_out}, {3'b100, 8'h00});
        DIR = 1'b0;
        NXT = 1'b0;
        tick();
        check("cmd_abort_pulse", tx.tx_aborted, 0);

        // DIR rising in DATA.
        set_payload(4, 4, 1'b1, 1'b0);
        start_pkt(PID_DATA0, 1'b0);
        tick();
        NXT = 1'b1;
        @(negedge CLKOUT);
        check("data_first_ready", tx.pl_ready, 1);
        tick();
        pl_idx = 1;
        drive_pl();
        check("data_first_byte", data_out, pay[0]);
        NXT = 1'b0;
        DIR = 1'b1;
        tick();
        check("data_abort",
              {tx.tx_aborted, STP, tx.tx_busy, data_out}, {3'b100, 8'h00});
        DIR = 1'b0;
        tick();
        check("data_abort_pulse", {tx.tx_aborted, tx.tx_busy}, 0);

        for (int n = 0; n < 40; n++) begin
            pid = 4'($urandom);
            len = $urandom_range(0, MAX_LEN + 3);
            zlp = (pid[1:0] == 2'b11) ? (len == 0 || $urandom_range(0, 6) == 0)
                                      : 1'($urandom);
            set_payload(len,
                        ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len,
                        $urandom_range(0, 9) != 0, 1'b0);
            model(pid, zlp);
            run_pkt(pid, zlp, $urandom_range(30, 100),
                    $sformatf("rnd%0d", n), endk);
        end

        // Reset in the middle of a payload.
        set_payload(4, 4, 1'b1, 1'b0);
        start_pkt(PID_DATA1, 1'b0);
        tick();
        NXT = 1'b1;
        tick();
        pl_idx = 1;
        drive_pl();
        check("mid_busy", tx.tx_busy, 1);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_reset_outputs",
              {STP, data_out, tx.tx_busy, tx.tx_done, tx.tx_aborted}, 0);
        check("mid_reset_ready", tx.pl_ready, 0);
        NXT = 1'b0;
        @(negedge CLKOUT);
        RESET = 1'b1;
        tick();
        check("post_reset_idle", {STP, data_out, tx.tx_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
